// File: rtl/galois_lfsr_16bit_checker.sv
// PRBS16 receive checker (x^16+x^5+x^4+x^3+1): hunts, verifies, then locks and counts word/bit errors.
// Outputs registered one cycle after the sampled word; no backpressure, the checker idles while data_valid=0.
module galois_lfsr_16bit_checker #(
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_CNT_W  = 32
) (
  input  logic                 CLK,
  input  logic                 rstb,
  input  logic                 data_valid,
  input  logic [15:0]          data_in,
  input  logic                 clear_counts,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] word_err_count,
  output logic [ERR_CNT_W-1:0] bit_err_count
);

  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int MS = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
  localparam int SW = ERR_CNT_W + 1;
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [MS-1:0] LOSS_LAST = MS'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            exp_q, exp_d;
  logic [MW-1:0]          match_q, match_d;
  logic [MS-1:0]          miss_q, miss_d;
  logic                   locked_q, locked_d;
  logic                   error_q, error_d;
  logic [ERR_CNT_W-1:0]   word_q, word_d;
  logic [ERR_CNT_W-1:0]   bit_q, bit_d;

  logic [15:0]            diff;
  logic                   mismatch;
  logic [4:0]             pop;
  logic                   count_en;
  logic [SW-1:0]          bit_sum;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n    = {s[14:0], s[15]};
    n[3] = s[2] ^ s[15];
    n[4] = s[3] ^ s[15];
    n[5] = s[4] ^ s[15];
    return n;
  endfunction

  always_comb begin
    diff     = data_in ^ exp_q;
    mismatch = |diff;
    pop      = '0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + {4'b0000, diff[i]};
    end
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    match_d  = match_q;
    miss_d   = miss_q;
    error_d  = 1'b0;
    count_en = 1'b0;

    if (data_valid) begin
      case (state_q)
        ST_HUNT: begin
          // All-zero is the LFSR lock-up state and can never seed a valid sequence.
          if (data_in != '0) begin
            exp_d   = lfsr_next(data_in);
            match_d = '0;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (data_in == '0) begin
            state_d = ST_HUNT;
          end else if (!mismatch) begin
            exp_d = lfsr_next(exp_q);
            if (match_q == LOCK_LAST) begin
              state_d = ST_LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            exp_d   = lfsr_next(data_in);
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Free-running once locked so a corrupted word cannot pull the reference off track.
          exp_d = lfsr_next(exp_q);
          if (mismatch) begin
            error_d  = 1'b1;
            count_en = 1'b1;
            if (miss_q == LOSS_LAST) begin
              state_d = ST_HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_comb begin
    word_d  = word_q;
    bit_d   = bit_q;
    bit_sum = {1'b0, bit_q} + SW'(pop);
    if (clear_counts) begin
      word_d = '0;
      bit_d  = '0;
    end else if (count_en) begin
      word_d = (&word_q) ? word_q : word_q + 1'b1;
      bit_d  = bit_sum[SW-1] ? '1 : bit_sum[ERR_CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_HUNT;
      exp_q    <= 16'hFFFF;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      word_q   <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      word_q   <= word_d;
      bit_q    <= bit_d;
    end
  end

  assign locked         = locked_q;
  assign error          = error_q;
  assign word_err_count = word_q;
  assign bit_err_count  = bit_q;

endmodule

// File: tb/tb_galois_lfsr_16bit_checker.sv
// Directed bench for the PRBS16 checker: lock acquisition, error counting, loss of lock, saturation, reset.
module tb_galois_lfsr_16bit_checker;

  logic        CLK = 1'b0;
  logic        rstb;
  logic        data_valid;
  logic        clear_counts;
  logic [15:0] data_in;

  logic        locked, error;
  logic [31:0] word_cnt, bit_cnt;
  logic        locked5, error5;
  logic [4:0]  word_cnt5, bit_cnt5;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] g;
  logic        err_seen;

  always #5 CLK = ~CLK;

  galois_lfsr_16bit_checker dut (
    .CLK            (CLK),
    .rstb           (rstb),
    .data_valid     (data_valid),
    .data_in        (data_in),
    .clear_counts   (clear_counts),
    .locked         (locked),
    .error          (error),
    .word_err_count (word_cnt),
    .bit_err_count  (bit_cnt)
  );

  galois_lfsr_16bit_checker #(.ERR_CNT_W(5)) dut5 (
    .CLK            (CLK),
    .rstb           (rstb),
    .data_valid     (data_valid),
    .data_in        (data_in),
    .clear_counts   (clear_counts),
    .locked         (locked5),
    .error          (error5),
    .word_err_count (word_cnt5),
    .bit_err_count  (bit_cnt5)
  );

  function automatic logic [15:0] nxt(input logic [15:0] s);
    logic [15:0] n;
    n[0] = s[15];
    n[1] = s[0];
    n[2] = s[1];
    n[3] = s[2] ^ s[15];
    n[4] = s[3] ^ s[15];
    n[5] = s[4] ^ s[15];
    for (int i = 6; i < 16; i++) n[i] = s[i-1];
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic drive(input logic v, input logic [15:0] w, input logic clr);
    data_valid   = v;
    data_in      = w;
    clear_counts = clr;
    @(negedge CLK);
    err_seen = err_seen | error;
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, g, 1'b0);
      g = nxt(g);
    end
  endtask

  task automatic send_bad(input logic [15:0] mask, input logic clr);
    drive(1'b1, g ^ mask, clr);
    g = nxt(g);
  endtask

  initial begin
    rstb = 1'b1; data_valid = 1'b0; data_in = '0; clear_counts = 1'b0; err_seen = 1'b0;
    #1 rstb = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_locked", locked, 0);
    check("rst_error", error, 0);
    check("rst_word", word_cnt, 0);
    check("rst_bit", bit_cnt, 0);
    rstb = 1'b1;
    @(negedge CLK);

    // Seed 0xFFFF, then 16 matching words from the generator.
    drive(1'b1, 16'hFFFF, 1'b0);
    drive(1'b1, 16'hFFC7, 1'b0);
    drive(1'b1, 16'hFFB7, 1'b0);
    g = nxt(16'hFFB7);
    send_clean(13);
    check("lock_early", locked, 0);
    send_clean(1);
    check("lock_rise", locked, 1);
    check("lock_no_err", err_seen, 0);
    check("lock_word0", word_cnt, 0);
    check("lock_bit0", bit_cnt, 0);

    // Single bit-0 flip while locked.
    send_bad(16'h0001, 1'b0);
    check("b0_error", error, 1);
    check("b0_word", word_cnt, 1);
    check("b0_bit", bit_cnt, 1);
    check("b0_locked", locked, 1);
    drive(1'b0, 16'h1234, 1'b0);
    check("gap_error", error, 0);
    send_clean(1);
    check("gap_hold_exp", error, 0);
    send_clean(5);
    check("b0_word_hold", word_cnt, 1);
    check("b0_locked_hold", locked, 1);

    // Clear, then one word with the low byte inverted.
    drive(1'b1, g, 1'b1);
    g = nxt(g);
    check("clr_word", word_cnt, 0);
    check("clr_bit", bit_cnt, 0);
    send_bad(16'h00FF, 1'b0);
    check("ff_word", word_cnt, 1);
    check("ff_bit", bit_cnt, 8);

    // Four consecutive bad words drop lock; the clean stream relocks after 1+16 words.
    drive(1'b1, g, 1'b1);
    g = nxt(g);
    for (int i = 0; i < 3; i++) send_bad(16'h8000, 1'b0);
    check("loss_3_locked", locked, 1);
    send_bad(16'h8000, 1'b0);
    check("loss_4_locked", locked, 0);
    check("loss_4_error", error, 1);
    check("loss_word", word_cnt, 4);
    check("loss_bit", bit_cnt, 4);
    send_clean(16);
    check("relock_early", locked, 0);
    send_clean(1);
    check("relock", locked, 1);

    // Asynchronous reset mid-lock.
    #2 rstb = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_word", word_cnt, 0);
    @(negedge CLK);
    rstb = 1'b1;

    // Zero words are ignored in HUNT and abort VERIFY; idle gaps do not disturb VERIFY.
    repeat (3) drive(1'b1, 16'h0000, 1'b0);
    check("zero_hunt", locked, 0);
    g = 16'hACE1;
    send_clean(6);
    drive(1'b1, 16'h0000, 1'b0);
    send_clean(9);
    repeat (3) drive(1'b0, 16'h5555, 1'b0);
    send_clean(7);
    check("gap_lock_early", locked, 0);
    send_clean(1);
    check("gap_lock", locked, 1);

    // 5-bit counters: 16-bit errors saturate the bit counter at 31.
    drive(1'b1, g, 1'b1);
    g = nxt(g);
    check("sat_clr", bit_cnt5, 0);
    send_bad(16'hFFFF, 1'b0);
    check("sat1_bit", bit_cnt5, 16);
    check("sat1_word", word_cnt5, 1);
    send_bad(16'hFFFF, 1'b0);
    check("sat2_bit", bit_cnt5, 31);
    check("sat2_word", word_cnt5, 2);
    check("wide_bit32", bit_cnt, 32);
    send_bad(16'hFFFF, 1'b0);
    check("sat3_bit", bit_cnt5, 31);
    check("sat3_word", word_cnt5, 3);
    send_clean(1);
    send_bad(16'hFFFF, 1'b1);
    check("clrerr_error", error5, 1);
    check("clrerr_word", word_cnt5, 0);
    check("clrerr_bit", bit_cnt5, 0);
    check("clrerr_locked", locked5, 1);
    check("clrerr_wide", word_cnt, 0);

    #2 rstb = 1'b0;
    #1;
    check("arst5_locked", locked5, 0);
    check("arst_locked2", locked, 0);
    @(negedge CLK);
    rstb = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
